// File: rtl/mac_t_frame_loader_pkg.sv
// Shared MAC-side definitions for the egress frame loader.
//   MAX_LEN      largest frame accepted without FCS
//   MIN_LEN      minimum Ethernet payload+header; padding is the MAC's job
//   PTR_LEN_MSB  top bit of the length field in a pointer word
//   ptr_word_t   16-bit pointer FIFO word {5'b0, len[10:0]}
//   ld_state_e   loader FSM states
package mac_pkg;
  localparam int MAX_LEN     = 1514;
  localparam int MIN_LEN     = 60;
  localparam int PTR_LEN_MSB = 10;

  typedef struct packed {
    logic [15-PTR_LEN_MSB-1:0] rsvd;
    logic [PTR_LEN_MSB:0]      len;
  } ptr_word_t;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DROP = 2'd2
  } ld_state_e;

  function automatic ptr_word_t mk_ptr(input logic [PTR_LEN_MSB:0] len);
    ptr_word_t w;
    w.rsvd = '0;
    w.len  = len;
    return w;
  endfunction
endpackage

// File: rtl/mac_t_frame_loader_sync_fifo_w16.sv
// 16-bit synchronous FIFO, 2^AW entries, registered read data.
//   clk, rst   clock, synchronous active-high reset
//   wr, din    push (ignored when full)
//   rd, dout   pop (ignored when empty); dout updates the cycle after rd and holds
//   empty/full status from registered pointers
module sync_fifo_w16 #(
  parameter int AW = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [15:0] din,
  input  logic        rd,
  output logic [15:0] dout,
  output logic        empty,
  output logic        full
);
  logic [15:0] mem [2**AW];
  logic [AW:0] wp, rp;
  logic        do_wr, do_rd;

  assign empty = (wp == rp);
  // same slot, different lap
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp   <= '0;
      rp   <= '0;
      dout <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) begin
        dout <= mem[rp[AW-1:0]];
        rp   <= rp + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mac_t_frame_loader.sv
// Store-and-forward egress frame loader in front of the GMII TX MAC.
// Buffers one sop..eop byte stream at a time; only error-free frames of
// at most MAX_LEN bytes are committed to the data buffer and announced
// through the pointer FIFO. The MAC pops whole frames byte by byte.
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/ready/data/sop/eop/err  ingress byte stream
//   data_fifo_rd, data_fifo_dout   committed byte pop, dout one cycle later
//   ptr_fifo_rd, ptr_fifo_dout     frame length pop {5'b0,len}
//   ptr_fifo_empty                 no committed frame pending
//   frame_ok, frame_drop           one-cycle pulses per committed/dropped frame
module mac_t_frame_loader #(
  parameter int DATA_AW = 12,
  parameter int PTR_AW  = 5,
  parameter int MAX_LEN = mac_pkg::MAX_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic        in_err,
  input  logic        data_fifo_rd,
  output logic [7:0]  data_fifo_dout,
  input  logic        ptr_fifo_rd,
  output logic [15:0] ptr_fifo_dout,
  output logic        ptr_fifo_empty,
  output logic        frame_ok,
  output logic        frame_drop
);
  import mac_pkg::*;

  localparam int PW = DATA_AW + 1;
  localparam logic [PW-1:0]          BUF_BYTES = PW'(2**DATA_AW);
  localparam logic [PW-1:0]          MAX_LEN_W = PW'(MAX_LEN);
  localparam logic [PTR_LEN_MSB:0]   MAX_LEN_L = (PTR_LEN_MSB+1)'(MAX_LEN);

  ld_state_e state, state_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt, wr_start, wr_start_nxt, rd_ptr;
  logic [PW-1:0] free, base;
  logic [PTR_LEN_MSB:0] len, len_nxt, blen;
  logic accept, take, wr_en, push, ok_nxt, drop_nxt, ptr_full, data_rd;
  logic [7:0] mem [2**DATA_AW];

  // speculative bytes (wr_ptr beyond wr_start) count as used
  assign free   = BUF_BYTES - (wr_ptr - rd_ptr);
  assign accept = in_valid & in_ready;
  // a sop always (re)starts at wr_start, which equals wr_ptr when idle
  assign base   = in_sop ? wr_start : wr_ptr;
  assign blen   = in_sop ? (PTR_LEN_MSB+1)'(1) : len + 1'b1;
  // byte is stored: sop in IDLE/LOAD, or a continuation that still fits
  assign take   = accept & (((state == LD_IDLE) & in_sop) |
                            ((state == LD_LOAD) & (in_sop | (len != MAX_LEN_L))));

  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    wr_en        = 1'b0;
    wr_ptr_nxt   = wr_ptr;
    wr_start_nxt = wr_start;
    len_nxt      = len;
    push         = 1'b0;
    ok_nxt       = 1'b0;
    drop_nxt     = 1'b0;

    case (state)
      LD_IDLE: begin
        // admit a frame only if a max-size frame and its pointer both fit
        in_ready = ~rst & (free >= MAX_LEN_W) & ~ptr_full;
        if (accept & ~in_sop) drop_nxt = 1'b1;
      end
      LD_LOAD: begin
        in_ready = ~rst;
        if (accept & in_sop) drop_nxt = 1'b1;   // stray sop kills current frame
        if (accept & ~in_sop & (len == MAX_LEN_L)) begin
          wr_ptr_nxt = wr_start;
          if (in_eop) begin
            drop_nxt  = 1'b1;
            state_nxt = LD_IDLE;
          end else begin
            state_nxt = LD_DROP;
          end
        end
      end
      LD_DROP: begin
        in_ready = ~rst;
        if (accept & in_eop) begin
          drop_nxt  = 1'b1;
          state_nxt = LD_IDLE;
        end
      end
      default: state_nxt = LD_IDLE;
    endcase

    if (take) begin
      wr_en      = 1'b1;
      wr_ptr_nxt = base + 1'b1;
      len_nxt    = blen;
      state_nxt  = LD_LOAD;
      if (in_eop) begin
        state_nxt = LD_IDLE;
        if (in_err) begin
          wr_ptr_nxt = wr_start;
          drop_nxt   = 1'b1;
        end else begin
          push         = 1'b1;
          wr_start_nxt = base + 1'b1;
          ok_nxt       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LD_IDLE;
      wr_ptr     <= '0;
      wr_start   <= '0;
      len        <= '0;
      frame_ok   <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      wr_start   <= wr_start_nxt;
      len        <= len_nxt;
      frame_ok   <= ok_nxt;
      frame_drop <= drop_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[base[DATA_AW-1:0]] <= in_data;
  end

  // only committed bytes (below wr_start) are visible to the MAC
  assign data_rd = data_fifo_rd & (rd_ptr != wr_start);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr         <= '0;
      data_fifo_dout <= '0;
    end else if (data_rd) begin
      data_fifo_dout <= mem[rd_ptr[DATA_AW-1:0]];
      rd_ptr         <= rd_ptr + 1'b1;
    end
  end

  sync_fifo_w16 #(.AW(PTR_AW)) u_ptr_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (push),
    .din   (16'(mk_ptr(blen))),
    .rd    (ptr_fifo_rd),
    .dout  (ptr_fifo_dout),
    .empty (ptr_fifo_empty),
    .full  (ptr_full)
  );
endmodule

// File: tb/tb_mac_t_frame_loader.sv
module tb_mac_t_frame_loader;
  localparam int MAXL = 1514;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_err = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        data_fifo_rd = 1'b0, ptr_fifo_rd = 1'b0;
  logic [7:0]  data_fifo_dout;
  logic [15:0] ptr_fifo_dout;
  logic        ptr_fifo_empty, frame_ok, frame_drop;

  always #5 clk = ~clk;

  mac_t_frame_loader dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_err(in_err),
    .data_fifo_rd(data_fifo_rd), .data_fifo_dout(data_fifo_dout),
    .ptr_fifo_rd(ptr_fifo_rd), .ptr_fifo_dout(ptr_fifo_dout),
    .ptr_fifo_empty(ptr_fifo_empty),
    .frame_ok(frame_ok), .frame_drop(frame_drop)
  );

  int vectors = 0, miscompares = 0;
  int exp_ok = 0, exp_drop = 0, ok_seen = 0, drop_seen = 0;
  int         exp_len_q[$];
  logic [7:0] exp_byte_q[$];
  bit rd_on = 0, rd_busy = 0, rd_gaps = 0, mon_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the byte was taken
  task automatic send_byte(input logic [7:0] d, input bit sop, input bit eop, input bit err);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop; in_err = err;
    while (!in_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_err = 1'b0;
  endtask

  // reference: a frame survives iff it ends with eop, no err, and len <= MAXL
  task automatic send_frame(input int len, input bit err, input bit trunc, input bit incr);
    logic [7:0] b[$];
    for (int i = 0; i < len; i++) b.push_back(incr ? 8'(i) : 8'($urandom));
    if (trunc || err || len > MAXL) exp_drop++;
    else begin
      exp_ok++;
      exp_len_q.push_back(len);
      foreach (b[i]) exp_byte_q.push_back(b[i]);
    end
    for (int i = 0; i < len; i++)
      send_byte(b[i], i == 0, !trunc && i == len - 1, err && i == len - 1);
  endtask

  // scoreboard side: pop one pointer, then that many bytes
  task automatic pop_frame(input bit chk_rdy);
    logic [15:0] w;
    int n;
    rd_busy = 1;
    ptr_fifo_rd = 1'b1;
    @(negedge clk);
    ptr_fifo_rd = 1'b0;
    w = ptr_fifo_dout;
    if (chk_rdy) chk("ready_after_ptr_pop", in_ready, 1);
    if (exp_len_q.size() == 0) begin
      chk("unexpected_frame_ptr", w, 16'hFFFF);
    end else begin
      n = exp_len_q.pop_front();
      chk("ptr_word", w, {5'b0, 11'(n)});
      for (int i = 0; i < n; i++) begin
        if (rd_gaps) while ($urandom_range(7) == 0) @(negedge clk);
        data_fifo_rd = 1'b1;
        @(negedge clk);
        data_fifo_rd = 1'b0;
        chk("data_byte", data_fifo_dout, exp_byte_q.size() ? exp_byte_q.pop_front() : 8'hxx);
      end
    end
    rd_busy = 0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_len_q.size() != 0 || rd_busy) && t < 50000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending_frames", exp_len_q.size(), 0);
  endtask

  task automatic chk_counts(input string tag);
    @(negedge clk);
    #1;
    chk({tag, "_ok_count"}, ok_seen, exp_ok);
    chk({tag, "_drop_count"}, drop_seen, exp_drop);
  endtask

  initial forever begin
    @(negedge clk);
    if (rd_on && !rd_busy && !ptr_fifo_empty) pop_frame(1'b0);
  end

  always @(negedge clk)
    if (mon_on) begin
      ok_seen   += int'(frame_ok);
      drop_seen += int'(frame_drop);
    end

  initial begin
    int r, len;
    bit err, trunc;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ptr_empty", ptr_fifo_empty, 1);
    chk("rst_data_dout", data_fifo_dout, 0);
    chk("rst_ptr_dout", ptr_fifo_dout, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_frame_drop", frame_drop, 0);
    rst = 1'b0;
    mon_on = 1;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1);

    // 60B incrementing frame
    send_frame(60, 0, 0, 1);
    chk("empty_after_commit", ptr_fifo_empty, exp_len_q.size() == 0);
    pop_frame(0);
    chk_counts("good60");

    // error at eop
    send_frame(64, 1, 0, 0);
    @(negedge clk);
    chk("empty_after_err", ptr_fifo_empty, exp_len_q.size() == 0);
    chk_counts("err64");

    // byte without sop while idle
    send_byte(8'hAA, 0, 1, 0);
    exp_drop++;
    chk_counts("nosop");

    // oversize then normal, then exact boundaries
    send_frame(1600, 0, 0, 0);
    send_frame(100, 0, 0, 0);
    pop_frame(0);
    send_frame(MAXL, 0, 0, 0);
    send_frame(MAXL + 1, 0, 0, 0);
    pop_frame(0);
    chk_counts("oversize");

    // stray sop mid-frame
    send_frame(20, 0, 1, 0);
    send_frame(50, 0, 0, 0);
    pop_frame(0);
    chk_counts("stray_sop");

    // fill the pointer FIFO with no reads
    for (int i = 0; i < 32; i++) send_frame(60, 0, 0, 0);
    chk("ready_when_ptr_full", in_ready, exp_len_q.size() < 32);
    pop_frame(1);
    rd_on = 1;
    wait_drain();
    chk_counts("fill32");

    // random traffic across many buffer wraps
    rd_gaps = 1;
    for (int i = 0; i < 200; i++) begin
      r     = $urandom_range(99);
      len   = $urandom_range(2, 250);
      err   = (r < 10);
      trunc = (r >= 10 && r < 15 && i != 199);
      if (r >= 15 && r < 17) len = $urandom_range(MAXL + 2, 1600);
      send_frame(len, err, trunc, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain();
    chk_counts("random");

    // reset in the middle of a frame
    for (int i = 0; i < 30; i++) send_byte(8'(i + 7), i == 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_ptr_empty", ptr_fifo_empty, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(40, 0, 0, 1);
    wait_drain();
    chk_counts("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
